// File: rtl/cic_sample_fifo_if.sv
// Readout interface of the CIC sample FIFO.
//   master (FIFO side)    : drives dout, dout_valid, fifo_count; samples dout_ready
//   slave  (consumer side): samples dout, dout_valid, fifo_count; drives dout_ready
// A word transfers on every clock edge where dout_valid and dout_ready are both high.
interface cic_sample_fifo_if #(
    parameter int OUT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8
);
    logic [OUT_WIDTH-1:0]         dout;
    logic                         dout_valid;
    logic                         dout_ready;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;

    modport master (
        output dout,
        output dout_valid,
        output fifo_count,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  fifo_count,
        output dout_ready
    );
endinterface

// File: rtl/cic_sample_fifo.sv
// CIC3 decimator output sampler with settle discard, scale/saturate and a
// show-ahead FIFO.
//
// The CIC output register is free running and changes once per decimation
// period. A local phase counter, reset together with the CIC clock counter,
// picks the middle of the stable window for the capture. The first
// SETTLE_SAMPLES captures after enable rises (or after reset) are thrown
// away while the filter settles. Accepted samples are shifted down to
// OUT_WIDTH bits, saturated, and written into the FIFO.
//
// Ports:
//   clk           modulator clock shared with the CIC
//   reset_n       asynchronous reset, active low
//   enable        capture enable (level)
//   cic_in        unsigned CIC3 output, NUMBITS wide
//   clear_ovf     synchronous clear of the sticky overflow flag
//   sample_strobe one-cycle pulse at each capture phase while enabled
//   overflow      sticky: a word was dropped because the FIFO was full
//   rd            readout interface (dout/dout_valid/dout_ready/fifo_count)
module cic_sample_fifo #(
    parameter int DECIMATION_FACTOR = 256,
    parameter int CLOCK_WIDTH       = $clog2(DECIMATION_FACTOR),
    parameter int NUMBITS           = 3*CLOCK_WIDTH+1,
    parameter int OUT_WIDTH         = 16,
    parameter int FIFO_DEPTH        = 8,
    parameter int CAPTURE_PHASE     = DECIMATION_FACTOR/2,
    parameter int SETTLE_SAMPLES    = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [NUMBITS-1:0]  cic_in,
    input  logic                clear_ovf,
    output logic                sample_strobe,
    output logic                overflow,
    cic_sample_fifo_if.master   rd
);

    localparam int SHIFT    = NUMBITS-1-OUT_WIDTH;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH)+1;
    localparam int SETTLE_W = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES+1) : 1;

    localparam logic [CLOCK_WIDTH-1:0] PHASE_LAST    = CLOCK_WIDTH'(DECIMATION_FACTOR-1);
    localparam logic [CLOCK_WIDTH-1:0] PHASE_CAPTURE = CLOCK_WIDTH'(CAPTURE_PHASE);
    localparam logic [SETTLE_W-1:0]    SETTLE_TARGET = SETTLE_W'(SETTLE_SAMPLES);
    localparam logic [CNT_W-1:0]       FULL_COUNT    = CNT_W'(FIFO_DEPTH);

    // Drop the SHIFT LSBs; anything left above OUT_WIDTH bits clamps to full scale.
    function automatic logic [OUT_WIDTH-1:0] scale_sat(input logic [NUMBITS-1:0] x);
        logic [NUMBITS-1:0] v;
        v = x >> SHIFT;
        if (|(v >> OUT_WIDTH))
            scale_sat = '1;
        else
            scale_sat = v[OUT_WIDTH-1:0];
    endfunction

    logic [CLOCK_WIDTH-1:0] phase_cnt;
    logic [SETTLE_W-1:0]    settle_cnt;
    logic                   settle_done;
    logic                   accept;

    logic                   vld_p1;
    logic [OUT_WIDTH-1:0]   data_p1;

    logic [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   full;
    logic                   pop;
    logic                   wr_en;
    logic                   drop;

    // ---- stage 0: capture phase and settle discard ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            phase_cnt <= '0;
        else if (phase_cnt == PHASE_LAST)
            phase_cnt <= '0;
        else
            phase_cnt <= phase_cnt + 1'b1;
    end

    assign sample_strobe = enable && (phase_cnt == PHASE_CAPTURE);
    assign settle_done   = (settle_cnt >= SETTLE_TARGET);
    assign accept        = sample_strobe && settle_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            settle_cnt <= '0;
        else if (!enable)
            settle_cnt <= '0;
        else if (sample_strobe && !settle_done)
            settle_cnt <= settle_cnt + 1'b1;
    end

    // ---- stage 1: scale and saturate the accepted sample ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept)
            data_p1 <= scale_sat(cic_in);
    end

    // ---- stage 2: FIFO write ----
    assign full  = (count == FULL_COUNT);
    assign pop   = rd.dout_valid && rd.dout_ready;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign wr_en = vld_p1 && (!full || pop);
    assign drop  = vld_p1 && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= data_p1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as clear_ovf leaves the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (clear_ovf)
            overflow <= 1'b0;
    end

    assign rd.fifo_count = count;
    assign rd.dout_valid = (count != '0);
    assign rd.dout       = rd.dout_valid ? mem[rd_ptr] : '0;

endmodule
